// File: rtl/adder_tree_ctrl.sv
// -----------------------------------------------------------------------------
// adder_tree_ctrl
//
// Sequencer for the pipelined pooling/reduction adder tree. Accepts reduction
// passes over a valid/ready handshake, steers the tree's global advance enable
// and per-lane input mask, tracks which tree stages hold live data so bubbles
// drain, and accumulates multi-pass groups into one wide signed result that is
// presented downstream behind a single output register with backpressure.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-low reset
//   soft_clear     synchronous flush of pipeline, accumulator and result
//   in_valid       pass offered
//   in_ready       pass accepted when in_valid && in_ready
//   in_lane_mask   live lanes for the offered pass
//   in_last        offered pass closes its group
//   adder_enable   advances every tree stage
//   mac_enable     lane mask for the word entering tree stage 1
//   adder_tree_out signed tree result at the last stage
//   out_valid      group result valid
//   out_ready      downstream accepts the result
//   out_sum        signed group sum (wraps at WID_ACC)
//   out_passes     number of passes in the reported group (saturating)
//   pass_overflow  sticky: some group exceeded MAX_PASSES
// -----------------------------------------------------------------------------
module adder_tree_ctrl #(
    parameter int N_PE        = 32,
    parameter int WID_PE_BITS = 16,
    parameter int TREE_LAT    = 5,
    parameter int MAX_PASSES  = 16,
    parameter int WID_ACC     = WID_PE_BITS + $clog2(MAX_PASSES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          soft_clear,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_PE-1:0]               in_lane_mask,
    input  logic                          in_last,
    output logic                          adder_enable,
    output logic [N_PE-1:0]               mac_enable,
    input  logic signed [WID_PE_BITS-1:0] adder_tree_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [WID_ACC-1:0]     out_sum,
    output logic [$clog2(MAX_PASSES):0]   out_passes,
    output logic                          pass_overflow
);

    localparam int PCNT_W = $clog2(MAX_PASSES) + 1;
    localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(MAX_PASSES);

    // Shadow of the tree stages: which stage holds a live pass, and whether
    // that pass closes its group. Bit 0 is stage 1, bit TREE_LAT-1 the tail.
    logic [TREE_LAT-1:0]       vld_sr;
    logic [TREE_LAT-1:0]       last_sr;
    logic signed [WID_ACC-1:0] acc;
    logic [PCNT_W-1:0]         pcnt;

    logic                      tail;
    logic                      tail_last;
    logic                      stall;
    logic                      accept;
    logic                      advance;
    logic                      consume;
    logic signed [WID_ACC-1:0] tree_ext;
    logic signed [WID_ACC-1:0] sum;
    logic [PCNT_W-1:0]         pcnt_inc;
    logic                      over_hit;
    logic [PCNT_W-1:0]         pcnt_sat;

    always_comb begin
        tail      = vld_sr[TREE_LAT-1];
        tail_last = tail & last_sr[TREE_LAT-1];
        // Only a closing pass needs the output register; a non-last tail pass
        // folds into acc and can always be consumed.
        stall     = tail_last & out_valid & ~out_ready;
        // in_ready depends on state, out_valid and out_ready only, never on
        // in_valid.
        in_ready  = ~stall & ~soft_clear;
        accept    = in_valid & in_ready;
        // Keep stepping while anything is live so bubbles drain to the tail.
        advance   = ~stall & ~soft_clear & (in_valid | (|vld_sr));
        consume   = advance & tail;

        adder_enable = advance;
        mac_enable   = accept ? in_lane_mask : '0;

        tree_ext = {{(WID_ACC-WID_PE_BITS){adder_tree_out[WID_PE_BITS-1]}}, adder_tree_out};
        sum      = acc + tree_ext;

        // pcnt never exceeds MAX_PASSES, so pcnt+1 always fits in PCNT_W.
        pcnt_inc = pcnt + PCNT_W'(1);
        over_hit = pcnt_inc > PCNT_MAX;
        pcnt_sat = over_hit ? PCNT_MAX : pcnt_inc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_sr        <= '0;
            last_sr       <= '0;
            acc           <= '0;
            pcnt          <= '0;
            out_valid     <= 1'b0;
            out_sum       <= '0;
            out_passes    <= '0;
            pass_overflow <= 1'b0;
        end else if (soft_clear) begin
            vld_sr        <= '0;
            last_sr       <= '0;
            acc           <= '0;
            pcnt          <= '0;
            out_valid     <= 1'b0;
            pass_overflow <= 1'b0;
        end else begin
            if (advance) begin
                vld_sr  <= {vld_sr[TREE_LAT-2:0], accept};
                last_sr <= {last_sr[TREE_LAT-2:0], accept & in_last};
            end

            if (consume) begin
                if (tail_last) begin
                    out_sum    <= sum;
                    out_passes <= pcnt_sat;
                    acc        <= '0;
                    pcnt       <= '0;
                end else begin
                    acc  <= sum;
                    pcnt <= pcnt_sat;
                end
                if (over_hit) begin
                    pass_overflow <= 1'b1;
                end
            end

            // A new result loading on the same edge as a take keeps valid high.
            if (consume & tail_last) begin
                out_valid <= 1'b1;
            end else if (out_valid & out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adder_tree_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adder_tree_ctrl
//
// Drives adder_tree_ctrl with a behavioural adder tree (a delay line that
// advances on adder_enable) and scores every delivered result against a
// group-level model: each accepted pass adds the masked lane sum to the open
// group, and a last pass closes the group into an expected-result queue.
// Directed cases cover latency, holding/backpressure, overflow and reset;
// a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_adder_tree_ctrl;

    localparam int N_PE        = 32;
    localparam int WID_PE_BITS = 16;
    localparam int TREE_LAT    = 5;
    localparam int MAX_PASSES  = 16;
    localparam int WID_ACC     = WID_PE_BITS + $clog2(MAX_PASSES);
    localparam int PW          = $clog2(MAX_PASSES) + 1;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          soft_clear;
    logic                          in_valid;
    logic                          in_ready;
    logic [N_PE-1:0]               in_lane_mask;
    logic                          in_last;
    logic                          adder_enable;
    logic [N_PE-1:0]               mac_enable;
    logic signed [WID_PE_BITS-1:0] adder_tree_out;
    logic                          out_valid;
    logic                          out_ready;
    logic [WID_ACC-1:0]            out_sum;
    logic [PW-1:0]                 out_passes;
    logic                          pass_overflow;

    always #5 clk = ~clk;

    adder_tree_ctrl #(
        .N_PE(N_PE), .WID_PE_BITS(WID_PE_BITS), .TREE_LAT(TREE_LAT),
        .MAX_PASSES(MAX_PASSES), .WID_ACC(WID_ACC)
    ) dut (
        .clk(clk), .rst(rst), .soft_clear(soft_clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_lane_mask(in_lane_mask), .in_last(in_last),
        .adder_enable(adder_enable), .mac_enable(mac_enable),
        .adder_tree_out(adder_tree_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_passes(out_passes),
        .pass_overflow(pass_overflow)
    );

    // ---------------- behavioural tree ----------------
    logic signed [WID_PE_BITS-1:0] lane_vals  [N_PE];
    logic signed [WID_PE_BITS-1:0] tree_stage [TREE_LAT];

    function automatic logic [WID_PE_BITS-1:0] pass_sum(input logic [N_PE-1:0] mask);
        logic [WID_PE_BITS-1:0] s;
        s = '0;
        for (int i = 0; i < N_PE; i++) begin
            if (mask[i]) s = s + lane_vals[i];
        end
        return s;
    endfunction

    always @(posedge clk) begin
        if (adder_enable) begin
            tree_stage[0] <= pass_sum(mac_enable);
            for (int i = 1; i < TREE_LAT; i++) tree_stage[i] <= tree_stage[i-1];
        end
    end
    assign adder_tree_out = tree_stage[TREE_LAT-1];

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- group-level reference model ----------------
    typedef struct {
        logic [WID_ACC-1:0] sum;
        int                 cnt;
    } res_t;

    res_t               exp_q[$];
    logic [WID_ACC-1:0] g_acc = '0;
    int                 g_cnt = 0;
    logic               exp_ovf = 1'b0;
    int                 n_results = 0;
    logic [WID_PE_BITS-1:0] mon_ps;
    res_t               mon_r;

    always @(negedge clk) begin
        if (!rst || soft_clear) begin
            exp_q.delete();
            g_acc   = '0;
            g_cnt   = 0;
            exp_ovf = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                mon_ps = pass_sum(in_lane_mask);
                g_acc  = g_acc + {{(WID_ACC-WID_PE_BITS){mon_ps[WID_PE_BITS-1]}}, mon_ps};
                g_cnt++;
                if (in_last) begin
                    mon_r.sum = g_acc;
                    mon_r.cnt = g_cnt;
                    exp_q.push_back(mon_r);
                    g_acc = '0;
                    g_cnt = 0;
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_result", 64'(out_valid), 64'(0));
                end else begin
                    mon_r = exp_q.pop_front();
                    if (mon_r.cnt > MAX_PASSES) exp_ovf = 1'b1;
                    n_results++;
                    $display("result %0d: sum=%0d passes=%0d (exp sum=%0d passes=%0d)",
                             n_results, $signed(out_sum), out_passes, $signed(mon_r.sum),
                             (mon_r.cnt > MAX_PASSES) ? MAX_PASSES : mon_r.cnt);
                    check_val("sb_out_sum", 64'(out_sum), 64'(mon_r.sum));
                    check_val("sb_out_passes", 64'(out_passes),
                              64'((mon_r.cnt > MAX_PASSES) ? MAX_PASSES : mon_r.cnt));
                    check_val("sb_pass_overflow", 64'(pass_overflow), 64'(exp_ovf));
                end
            end
        end
    end

    // ---------------- stimulus helpers (entered/left at posedge+1) ----------------
    task automatic set_lanes(input int v);
        for (int i = 0; i < N_PE; i++) lane_vals[i] = '0;
        lane_vals[0] = WID_PE_BITS'(v);
    endtask

    task automatic send_pass(input logic [N_PE-1:0] mask, input logic last);
        int w;
        in_valid     = 1'b1;
        in_lane_mask = mask;
        in_last      = last;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            w++;
            @(negedge clk);
        end
        if (w >= 50) check_val("accept_timeout", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [WID_ACC-1:0] exp_sum,
                               input int exp_passes);
        int w;
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 50) begin
            w++;
            @(negedge clk);
        end
        check_val({tag, "_valid"}, 64'(out_valid), 64'(1));
        check_val({tag, "_sum"}, 64'(out_sum), 64'(exp_sum));
        check_val({tag, "_passes"}, 64'(out_passes), 64'(exp_passes));
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        check_val({tag, "_out_sum"}, 64'(out_sum), 64'(0));
        check_val({tag, "_out_passes"}, 64'(out_passes), 64'(0));
        check_val({tag, "_pass_overflow"}, 64'(pass_overflow), 64'(0));
        check_val({tag, "_adder_enable"}, 64'(adder_enable), 64'(0));
        check_val({tag, "_mac_enable"}, 64'(mac_enable), 64'(0));
        check_val({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        int ae_cnt;
        int first;
        int drv_cnt;
        logic [WID_ACC-1:0] f_sum;
        logic [PW-1:0]      f_passes;
        logic acc_now;

        rst = 1'b0; soft_clear = 1'b0; in_valid = 1'b0; in_lane_mask = '0;
        in_last = 1'b0; out_ready = 1'b1;
        set_lanes(0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single pass, all lanes 1: latency and enable window.
        for (int i = 0; i < N_PE; i++) lane_vals[i] = 16'sd1;
        in_valid = 1'b1; in_lane_mask = '1; in_last = 1'b1;
        ae_cnt = 0; first = -1; f_sum = '0; f_passes = '0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (adder_enable) ae_cnt++;
            if (out_valid && first < 0) begin
                first = k; f_sum = out_sum; f_passes = out_passes;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0; in_last = 1'b0;
        end
        check_val("single_latency", 64'(first), 64'(TREE_LAT + 1));
        check_val("single_enable_cycles", 64'(ae_cnt), 64'(TREE_LAT + 1));
        check_val("single_sum", 64'(f_sum), 64'(32));
        check_val("single_passes", 64'(f_passes), 64'(1));

        // Three passes 10, -4, 7.
        set_lanes(10); send_pass('1, 1'b0);
        set_lanes(-4); send_pass('1, 1'b0);
        set_lanes(7);  send_pass('1, 1'b1);
        wait_result("three", WID_ACC'(13), 3);

        // Backpressure: two one-pass groups 5 and 9 with out_ready low.
        out_ready = 1'b0;
        set_lanes(5); send_pass('1, 1'b1);
        set_lanes(9); send_pass('1, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_val("hold_valid", 64'(out_valid), 64'(1));
        check_val("hold_sum", 64'(out_sum), 64'(5));
        check_val("hold_in_ready", 64'(in_ready), 64'(0));
        check_val("hold_adder_enable", 64'(adder_enable), 64'(0));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check_val("b2b_first_valid", 64'(out_valid), 64'(1));
        check_val("b2b_first_sum", 64'(out_sum), 64'(5));
        @(negedge clk);
        check_val("b2b_second_valid", 64'(out_valid), 64'(1));
        check_val("b2b_second_sum", 64'(out_sum), 64'(9));
        @(negedge clk);
        check_val("b2b_drained", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;

        // 17 passes in one group: overflow, saturated count.
        set_lanes(1);
        for (int i = 0; i < MAX_PASSES + 1; i++) send_pass('1, (i == MAX_PASSES));
        wait_result("ovf_group", WID_ACC'(17), MAX_PASSES);
        check_val("ovf_set", 64'(pass_overflow), 64'(1));
        set_lanes(2); send_pass('1, 1'b1);
        wait_result("ovf_next", WID_ACC'(2), 1);
        check_val("ovf_sticky", 64'(pass_overflow), 64'(1));
        soft_clear = 1'b1;
        @(negedge clk);
        check_val("sc_in_ready", 64'(in_ready), 64'(0));
        check_val("sc_adder_enable", 64'(adder_enable), 64'(0));
        @(posedge clk);
        #1;
        soft_clear = 1'b0;
        check_val("sc_ovf_cleared", 64'(pass_overflow), 64'(0));
        check_val("sc_out_valid", 64'(out_valid), 64'(0));

        // Reset with three passes in flight.
        set_lanes(3);
        send_pass('1, 1'b0);
        send_pass('1, 1'b0);
        send_pass('1, 1'b0);
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_lanes(8); send_pass('1, 1'b1);
        wait_result("post_reset", WID_ACC'(8), 1);

        // Randomized traffic, groups capped at MAX_PASSES.
        drv_cnt = 0;
        for (int c = 0; c < 600; c++) begin
            if (!in_valid && $urandom_range(99) < 70) begin
                for (int i = 0; i < N_PE; i++)
                    lane_vals[i] = WID_PE_BITS'(int'($urandom_range(127)) - 64);
                in_lane_mask = $urandom;
                in_last      = (drv_cnt == MAX_PASSES - 1) || ($urandom_range(3) == 0);
                in_valid     = 1'b1;
            end
            out_ready  = ($urandom_range(99) < 70);
            soft_clear = ($urandom_range(249) == 0);
            @(negedge clk);
            acc_now = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (soft_clear) begin
                soft_clear = 1'b0;
                drv_cnt    = 0;
                in_valid   = 1'b0;
                in_last    = 1'b0;
            end else if (acc_now) begin
                drv_cnt  = in_last ? 0 : drv_cnt + 1;
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check_val("drain_queue_empty", 64'(exp_q.size()), 64'(0));
        check_val("results_seen", 64'(n_results > 20), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
